// File: rtl/bsk_pkg.sv
// Shared constants and types for the BSK command transmitter (bsk_prd).
package bsk_pkg;

  localparam logic [5:0] VERSION        = 6'd1;
  localparam logic [7:0] UNIT_CODE_BASE = 8'hA6;
  localparam logic [7:0] ENABLE_CODE    = 8'hE1;
  // Upper two bits of the chip-select code; the low bits are {!unit, 1}.
  localparam logic [1:0] CS_CODE        = 2'b01;

  typedef enum logic [1:0] {
    ADDR_COM_LO = 2'd0,
    ADDR_COM_HI = 2'd1,
    ADDR_IND    = 2'd2,
    ADDR_CTRL   = 2'd3
  } addr_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Byte -> {hi nibble, ~hi nibble, lo nibble, ~lo nibble}, the format the receiver checks.
  function automatic logic [15:0] pack_nib(input logic [7:0] b);
    return {b[7:4], ~b[7:4], b[3:0], ~b[3:0]};
  endfunction

endpackage

// File: rtl/bsk_prd_if.sv
// CPU bus strobes of the BSK command transmitter.
// Bus protocol: iRd/iWr are active-low asynchronous strobes qualified by iCS/iA.
// A read is served combinationally while selected and iRd=0; a write commits on the
// synchronized rising edge of iWr, so iA/iCS/bD must stay stable a few clocks after it.
interface bsk_prd_if;
  logic       iRd;
  logic       iWr;
  logic [1:0] iA;
  logic [3:0] iCS;
  logic       oCS;

  modport master (output iRd, iWr, iA, iCS, input oCS);
  modport slave  (input iRd, iWr, iA, iCS, output oCS);
endinterface

// File: rtl/bsk_prd_debounce.sv
// One command channel: 2-flop synchronizer, tick-based debounce counter, filtered output.
// The filtered value toggles only after DEBOUNCE_LEN consecutive ticks of disagreement.
module bsk_prd_debounce #(
  parameter int DEBOUNCE_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic com_i,
  output logic filt_o
);
  localparam int CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Bring the opto-isolated input into the clock domain (idle level is 1).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= com_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing ticks; toggle on the DEBOUNCE_LEN-th one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (tick_i) begin
      if (sync2_q != filt_q) begin
        if (cnt_q == CW'(DEBOUNCE_LEN - 1)) begin
          filt_q <= ~filt_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_o = filt_q;
endmodule

// File: rtl/bsk_prd.sv
// BSK command transmitter: debounces 16 command inputs, freezes a snapshot for a
// two-read CPU transfer, and holds the indication/control registers.
// Optional watchdog on the control register: define BSK_PRD_WATCHDOG_EN.
module bsk_prd
  import bsk_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int DEBOUNCE_LEN = 8,
  parameter int LOCK_TICKS   = 64
`ifdef BSK_PRD_WATCHDOG_EN
  , parameter int WDT_TICKS  = 1000
`endif
) (
  input  logic             iClk,
  input  logic             iRes,
  bsk_prd_if.slave         bus,
  inout  wire  [15:0]      bD,
  input  logic             unit,
  input  logic             iBl,
  input  logic [15:0]      iCom,
  output logic [15:0]      oComInd,
  output logic             oEnable,
  output logic [15:0]      debug
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOCK_TICKS + 1);

  logic          cs, tick, enable, locked;
  logic [PW-1:0] presc_q;
  logic [15:0]   filt, snap_q, com_ind_q, rep, rd_data;
  logic [7:0]    control_q;
  logic [LW-1:0] lock_cnt_q;
  lock_state_e   state_q;
  logic          rd_m_q, rd_s_q, rd_p_q, wr_m_q, wr_s_q, wr_p_q;
  logic [1:0]    a_m_q, a_s_q, a_p_q;
  logic [15:0]   d_m_q, d_s_q, d_p_q;
  logic          rd_fall, rd_rise, wr_rise;

  assign cs      = (bus.iCS == {CS_CODE, ~unit, 1'b1});
  assign bus.oCS = ~cs;

  // Synchronize strobes, address and data; keep one extra stage for edge detection.
  always_ff @(posedge iClk) begin
    if (iRes) begin
      {rd_m_q, rd_s_q, rd_p_q} <= 3'b111;
      {wr_m_q, wr_s_q, wr_p_q} <= 3'b111;
      {a_m_q, a_s_q, a_p_q}    <= '0;
      {d_m_q, d_s_q, d_p_q}    <= '0;
    end else begin
      {rd_m_q, rd_s_q, rd_p_q} <= {bus.iRd, rd_m_q, rd_s_q};
      {wr_m_q, wr_s_q, wr_p_q} <= {bus.iWr, wr_m_q, wr_s_q};
      {a_m_q, a_s_q, a_p_q}    <= {bus.iA, a_m_q, a_s_q};
      {d_m_q, d_s_q, d_p_q}    <= {bD, d_m_q, d_s_q};
    end
  end

  assign rd_fall = rd_p_q & ~rd_s_q;
  assign rd_rise = ~rd_p_q & rd_s_q;
  assign wr_rise = ~wr_p_q & wr_s_q;

  // Debounce tick prescaler.
  always_ff @(posedge iClk) begin
    if (iRes)      presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < 16; g++) begin : g_ch
    bsk_prd_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .clk_i (iClk),
      .rst_i (iRes),
      .tick_i(tick),
      .com_i (iCom[g]),
      .filt_o(filt[g])
    );
  end

  // Lock FSM: track filtered inputs while idle, freeze them across the A0/A1 read pair.
  always_ff @(posedge iClk) begin
    if (iRes) begin
      state_q    <= IDLE;
      snap_q     <= 16'hFFFF;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_fall && cs && a_p_q == ADDR_COM_LO) begin
            state_q    <= LOCKED;
            lock_cnt_q <= '0;
          end else begin
            snap_q <= filt;
          end
        end
        LOCKED: begin
          if (rd_rise && cs && a_p_q == ADDR_COM_HI) begin
            state_q <= IDLE;
          end else if (rd_fall && cs && a_p_q == ADDR_COM_LO) begin
            lock_cnt_q <= '0;
          end else if (tick) begin
            if (lock_cnt_q == LW'(LOCK_TICKS - 1)) begin
              state_q    <= IDLE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign locked = (state_q == LOCKED);

`ifdef BSK_PRD_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  logic [WW-1:0] wdt_cnt_q;
  logic          wdt_exp_q;
`endif

  // Register writes on the synchronized iWr rising edge; watchdog may clear control.
  always_ff @(posedge iClk) begin
    if (iRes) begin
      com_ind_q <= '0;
      control_q <= '0;
`ifdef BSK_PRD_WATCHDOG_EN
      wdt_cnt_q <= '0;
      wdt_exp_q <= 1'b0;
`endif
    end else begin
      if (wr_rise && cs) begin
        case (a_p_q)
          ADDR_IND:  com_ind_q <= d_p_q;
          ADDR_CTRL: control_q <= d_p_q[7:0];
          default:   ;
        endcase
      end
`ifdef BSK_PRD_WATCHDOG_EN
      if (wr_rise && cs && a_p_q == ADDR_CTRL) begin
        wdt_cnt_q <= '0;
        wdt_exp_q <= 1'b0;
      end else if (tick) begin
        if (wdt_cnt_q == WW'(WDT_TICKS - 1)) begin
          control_q <= '0;
          wdt_exp_q <= 1'b1;
          wdt_cnt_q <= '0;
        end else begin
          wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

`ifdef BSK_PRD_WATCHDOG_EN
  assign debug = {15'd0, wdt_exp_q};
`else
  assign debug = 16'h0000;
`endif

  assign enable  = (control_q == ENABLE_CODE);
  assign oEnable = ~enable | iBl;
  assign oComInd = ~com_ind_q;
  assign rep     = (iBl || !enable) ? 16'hFFFF : snap_q;

  // Read data mux, selected by the raw bus address.
  always_comb begin
    rd_data = '0;
    case (bus.iA)
      ADDR_COM_LO: rd_data = pack_nib(rep[7:0]);
      ADDR_COM_HI: rd_data = pack_nib(rep[15:8]);
      ADDR_IND:    rd_data = com_ind_q;
      default:     rd_data = {UNIT_CODE_BASE + {7'd0, unit}, VERSION, locked, enable};
    endcase
  end

  assign bD = (cs && !bus.iRd) ? rd_data : 16'hzzzz;
endmodule

// File: tb/tb_bsk_prd.sv
// Self-checking bench for bsk_prd: directed bus transactions, expected values queued
// by the stimulus and compared by an independent monitor.
module tb_bsk_prd;
  localparam int TD = 10;
  localparam int DL = 8;
  localparam int LT = 64;
  localparam int WT = 400;

  localparam int K_BUS = 0;
  localparam int K_ENA = 1;
  localparam int K_IND = 2;
  localparam int K_DBG = 3;
  localparam int K_CS  = 4;

  logic        iClk = 1'b0;
  logic        iRes = 1'b1;
  logic        unit = 1'b0;
  logic        iBl  = 1'b0;
  logic [15:0] iCom = 16'hFFFF;
  logic [15:0] oComInd, debug;
  logic        oEnable;
  logic        tb_en = 1'b0;
  logic [15:0] tb_d  = '0;
  wire  [15:0] bD;

  bsk_prd_if bif ();

  assign bD = tb_en ? tb_d : 16'hzzzz;

  bsk_prd #(
    .TICK_DIV(TD), .DEBOUNCE_LEN(DL), .LOCK_TICKS(LT)
`ifdef BSK_PRD_WATCHDOG_EN
    , .WDT_TICKS(WT)
`endif
  ) dut (
    .iClk(iClk), .iRes(iRes), .bus(bif), .bD(bD), .unit(unit), .iBl(iBl),
    .iCom(iCom), .oComInd(oComInd), .oEnable(oEnable), .debug(debug)
  );

  // Clock
  always #5 iClk = ~iClk;

  // Scoreboard state
  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        chk_req = 1'b0;
  logic        drain_req = 1'b0;

  // Monitor: pops one expectation per request and compares against the DUT output.
  always @(negedge iClk) begin
    logic [15:0] e, obs;
    int          k;
    string       n;
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: request with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_BUS:   obs = bD;
          K_ENA:   obs = {15'd0, oEnable};
          K_IND:   obs = oComInd;
          K_DBG:   obs = debug;
          default: obs = {15'd0, bif.oCS};
        endcase
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, obs, e);
        end
      end
    end
    if (drain_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
    end
  end

  function automatic logic [3:0] cs_code();
    return {2'b01, ~unit, 1'b1};
  endfunction

  task automatic expect_out(input int kind, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(name);
    chk_req = 1'b1;
    @(negedge iClk);
    #1 chk_req = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [15:0] exp, input string name);
    @(posedge iClk); #1;
    bif.iA  = a;
    bif.iCS = cs_code();
    @(posedge iClk); #1 bif.iRd = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    expect_out(K_BUS, exp, name);
    @(posedge iClk); #1 bif.iRd = 1'b1;
    repeat (4) @(posedge iClk);
    #1 bif.iCS = 4'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge iClk); #1;
    bif.iA  = a;
    bif.iCS = cs_code();
    tb_d    = d;
    tb_en   = 1'b1;
    @(posedge iClk); #1 bif.iWr = 1'b0;
    repeat (4) @(posedge iClk);
    #1 bif.iWr = 1'b1;
    repeat (4) @(posedge iClk);
    #1;
    tb_en   = 1'b0;
    bif.iCS = 4'h0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TD) @(posedge iClk);
    #1;
  endtask

  initial begin
    bif.iRd = 1'b1;
    bif.iWr = 1'b1;
    bif.iA  = 2'd0;
    bif.iCS = 4'h0;
    repeat (5) @(posedge iClk);
    #1 iRes = 1'b0;
    repeat (2) @(posedge iClk);
    #1;

    // Reset state
    expect_out(K_ENA, 16'h0001, "reset_oEnable");
    expect_out(K_IND, 16'hFFFF, "reset_oComInd");
    expect_out(K_CS,  16'h0001, "reset_oCS_unselected");
    expect_out(K_DBG, 16'h0000, "reset_debug");
    bus_read(2'd3, 16'hA604, "reset_read_a3");

    // Enable and debounce a single command
    bus_write(2'd3, 16'h00E1);
    expect_out(K_ENA, 16'h0000, "enable_oEnable");
    bus_read(2'd3, 16'hA605, "enable_read_a3");
    iCom = 16'hFFFE;
    wait_ticks(DL + 2);
    bus_read(2'd0, 16'hF0E1, "com0_read_a0");
    bus_read(2'd3, 16'hA607, "locked_read_a3");
    bus_read(2'd1, 16'hF0F0, "com0_read_a1");

    // Glitch of DL-1 ticks is rejected, DL+2 ticks is accepted
    iCom = 16'hFFFF;
    wait_ticks(DL + 2);
    iCom[5] = 1'b0;
    repeat ((DL - 1) * TD) @(posedge iClk);
    #1 iCom[5] = 1'b1;
    wait_ticks(2);
    bus_read(2'd0, 16'hF0F0, "glitch_read_a0");
    bus_read(2'd1, 16'hF0F0, "glitch_read_a1");
    iCom[5] = 1'b0;
    wait_ticks(DL + 2);
    bus_read(2'd0, 16'hD2F0, "com5_read_a0");
    bus_read(2'd1, 16'hF0F0, "com5_read_a1");
    iCom = 16'hFFFF;
    wait_ticks(DL + 2);

    // Snapshot holds across the read pair
    bus_read(2'd0, 16'hF0F0, "snap_read_a0");
    iCom = 16'h0000;
    wait_ticks(DL + 2);
    bus_read(2'd1, 16'hF0F0, "snap_old_read_a1");
    bus_read(2'd0, 16'h0F0F, "snap_new_read_a0");
    bus_read(2'd1, 16'h0F0F, "snap_new_read_a1");

    // Lock timeout releases the snapshot without an A=1 read
    bus_read(2'd0, 16'h0F0F, "timeout_lock_a0");
    iCom = 16'hFFFF;
    wait_ticks(LT + 6);
    bus_read(2'd3, 16'hA605, "timeout_read_a3");
    bus_read(2'd0, 16'hF0F0, "timeout_read_a0");
    bus_read(2'd1, 16'hF0F0, "timeout_read_a1");

    // Block forces FFFF; indication register
    iCom = 16'h0000;
    wait_ticks(DL + 2);
    bus_read(2'd0, 16'h0F0F, "active_read_a0");
    bus_read(2'd1, 16'h0F0F, "active_read_a1");
    iBl = 1'b1;
    #1;
    expect_out(K_ENA, 16'h0001, "block_oEnable");
    bus_read(2'd0, 16'hF0F0, "block_read_a0");
    bus_read(2'd1, 16'hF0F0, "block_read_a1");
    bus_write(2'd2, 16'h0005);
    expect_out(K_IND, 16'hFFFA, "ind_oComInd");
    bus_read(2'd2, 16'h0005, "ind_read_a2");
    iBl = 1'b0;
    #1;
    expect_out(K_ENA, 16'h0000, "unblock_oEnable");

    // Writes to A=0 are ignored; disabling control forces FFFF
    bus_write(2'd0, 16'h1234);
    bus_read(2'd2, 16'h0005, "ignored_read_a2");
    bus_read(2'd3, 16'hA605, "ignored_read_a3");
    bus_write(2'd3, 16'h0000);
    expect_out(K_ENA, 16'h0001, "disable_oEnable");
    bus_read(2'd0, 16'hF0F0, "disable_read_a0");
    bus_read(2'd1, 16'hF0F0, "disable_read_a1");

    // Unit 1 decoding
    unit = 1'b1;
    bif.iCS = 4'b0111;
    #1;
    expect_out(K_CS, 16'h0001, "unit1_wrong_cs");
    bif.iCS = 4'b0101;
    #1;
    expect_out(K_CS, 16'h0000, "unit1_right_cs");
    bif.iCS = 4'h0;
    bus_read(2'd3, 16'hA704, "unit1_read_a3");
    unit = 1'b0;

`ifdef BSK_PRD_WATCHDOG_EN
    bus_write(2'd3, 16'h00E1);
    expect_out(K_ENA, 16'h0000, "wdt_armed_oEnable");
    expect_out(K_DBG, 16'h0000, "wdt_armed_debug");
    wait_ticks(WT + 2);
    expect_out(K_ENA, 16'h0001, "wdt_expired_oEnable");
    expect_out(K_DBG, 16'h0001, "wdt_expired_debug");
    bus_read(2'd3, 16'hA604, "wdt_expired_read_a3");
    bus_write(2'd3, 16'h00E1);
    expect_out(K_DBG, 16'h0000, "wdt_cleared_debug");
    expect_out(K_ENA, 16'h0000, "wdt_cleared_oEnable");
`else
    expect_out(K_DBG, 16'h0000, "nowdt_debug");
`endif

    // Final report
    repeat (3) @(posedge iClk);
    #1 drain_req = 1'b1;
    @(negedge iClk);
    #1 drain_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "time limit");
  end
endmodule
